// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with pixel divider, sync/active decode and position flags
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit SYNC_POL = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int CW      = $clog2(H_TOTAL),
    localparam int RW      = $clog2(V_TOTAL),
    localparam int AW      = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          pixel_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] counter_out_col,
    output logic [RW-1:0] counter_out_row,
    output logic [AW-1:0] counter_out_addr,
    output logic          flag_col,
    output logic          flag_row,
    output logic          flag_addr
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int A_LAST = H_ACTIVE * V_ACTIVE - 1;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] col_d;
    logic [RW-1:0] row_d;
    logic [AW-1:0] addr_d;
    logic col_end, row_end, act_now, act_d, hs_d, vs_d, fc_d, fr_d, fa_d;
    // Next-state counters and decode of the outputs from the next position so both register together
    always_comb begin
        pixel_tick = enable && !rst && div_q == DW'(CLK_DIV - 1);
        div_d = enable ? (div_q == DW'(CLK_DIV - 1) ? '0 : div_q + DW'(1)) : div_q;
        col_end = counter_out_col == CW'(H_TOTAL - 1);
        row_end = counter_out_row == RW'(V_TOTAL - 1);
        act_now = counter_out_col < CW'(H_ACTIVE) && counter_out_row < RW'(V_ACTIVE);
        col_d = pixel_tick ? (col_end ? '0 : counter_out_col + CW'(1)) : counter_out_col;
        row_d = pixel_tick && col_end ? (row_end ? '0 : counter_out_row + RW'(1)) : counter_out_row;
        addr_d = pixel_tick && col_end && row_end ? '0 :
                 pixel_tick && act_now ? (counter_out_addr == AW'(A_LAST) ? '0 : counter_out_addr + AW'(1)) :
                 counter_out_addr;
        act_d = col_d < CW'(H_ACTIVE) && row_d < RW'(V_ACTIVE);
        hs_d = col_d >= CW'(H_ACTIVE + H_FP) && col_d < CW'(H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
        vs_d = row_d >= RW'(V_ACTIVE + V_FP) && row_d < RW'(V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
        fc_d = col_d == CW'(H_TOTAL - 1);
        fr_d = fc_d && row_d == RW'(V_TOTAL - 1);
        fa_d = act_d && addr_d == AW'(A_LAST);
    end
    // Position and decoded outputs share one register stage; with enable low every _d equals its _q
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            counter_out_col <= '0;
            counter_out_row <= '0;
            counter_out_addr <= '0;
            active <= 1'b1;
            hsync <= !SYNC_POL;
            vsync <= !SYNC_POL;
            flag_col <= 1'b0;
            flag_row <= 1'b0;
            flag_addr <= 1'b0;
        end else begin
            div_q <= div_d;
            counter_out_col <= col_d;
            counter_out_row <= row_d;
            counter_out_addr <= addr_d;
            active <= act_d;
            hsync <= hs_d;
            vsync <= vs_d;
            flag_col <= fc_d;
            flag_row <= fr_d;
            flag_addr <= fa_d;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized enable/reset against a frame-position reference model, CLK_DIV=2 and CLK_DIV=1 builds
module tb_video_timing_gen;
    typedef struct {
        int tick, hs, vs, act, col, row, addr, fc, fr, fa;
    } obs_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    obs_t q0[$], q1[$];
    logic tk0, hs0, vs0, ac0, fc0, fr0, fa0, tk1, hs1, vs1, ac1, fc1, fr1, fa1;
    logic [2:0] col0, col1;
    logic [2:0] row0, row1;
    logic [3:0] addr0, addr1;
    int ph[2];
    int pos[2];
    bit done = 0;
    always #5 clk = ~clk;
    video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .SYNC_POL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .pixel_tick(tk0), .hsync(hs0), .vsync(vs0), .active(ac0),
        .counter_out_col(col0), .counter_out_row(row0), .counter_out_addr(addr0),
        .flag_col(fc0), .flag_row(fr0), .flag_addr(fa0));
    video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .pixel_tick(tk1), .hsync(hs1), .vsync(vs1), .active(ac1),
        .counter_out_col(col1), .counter_out_row(row1), .counter_out_addr(addr1),
        .flag_col(fc1), .flag_row(fr1), .flag_addr(fa1));
    // Expected outputs for frame position p (0..47, 8 pixels x 6 lines) and a tick flag
    function automatic obs_t model(int p, int tick);
        obs_t e;
        e.col = p % 8;
        e.row = p / 8;
        e.tick = tick;
        e.act = int'(e.col < 4 && e.row < 3);
        e.hs = int'(!(e.col >= 5 && e.col < 7));
        e.vs = int'(e.row != 4);
        e.addr = e.row < 3 ? (e.row * 4 + (e.col < 4 ? e.col : 4)) % 12 : 0;
        e.fc = int'(e.col == 7);
        e.fr = int'(p == 47);
        e.fa = int'(e.act == 1 && e.addr == 11);
        return e;
    endfunction
    // Advance the model of DUT d by one clock edge under the current inputs and queue the expectation
    task automatic step(int d, int cd);
        obs_t e;
        if (rst) begin
            ph[d] = 0;
            pos[d] = 0;
        end else if (enable) begin
            if (ph[d] == cd - 1) pos[d] = (pos[d] + 1) % 48;
            ph[d] = (ph[d] + 1) % cd;
        end
        e = model(pos[d], int'(enable && !rst && ph[d] == cd - 1));
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask
    task automatic cmp(string n, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, exp);
        end
    endtask
    task automatic check(string d, obs_t a, obs_t e);
        cmp({d, ".pixel_tick"}, a.tick, e.tick);
        cmp({d, ".hsync"}, a.hs, e.hs);
        cmp({d, ".vsync"}, a.vs, e.vs);
        cmp({d, ".active"}, a.act, e.act);
        cmp({d, ".col"}, a.col, e.col);
        cmp({d, ".row"}, a.row, e.row);
        cmp({d, ".addr"}, a.addr, e.addr);
        cmp({d, ".flag_col"}, a.fc, e.fc);
        cmp({d, ".flag_row"}, a.fr, e.fr);
        cmp({d, ".flag_addr"}, a.fa, e.fa);
    endtask
    // Monitor: after every edge pop one expectation per DUT and compare against its outputs
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (q0.size() == 0 || q1.size() == 0) begin
                cmp("scoreboard_underflow", 0, 1);
                continue;
            end
            e = q0.pop_front();
            a = '{int'(tk0), int'(hs0), int'(vs0), int'(ac0), int'(col0), int'(row0), int'(addr0), int'(fc0), int'(fr0), int'(fa0)};
            check("div2", a, e);
            e = q1.pop_front();
            a = '{int'(tk1), int'(hs1), int'(vs1), int'(ac1), int'(col1), int'(row1), int'(addr1), int'(fc1), int'(fr1), int'(fa1)};
            check("div1", a, e);
        end
    end
    // Stimulus: two reset clocks, a clean full frame, then random enable drops and occasional resets
    initial begin
        for (int i = 0; i < 3000; i++) begin
            rst = i < 2 || (i > 200 && $urandom_range(0, 149) == 0);
            enable = i < 2 || (i >= 2 && i < 110) ? 1'b1 : ($urandom_range(0, 99) < 85);
            step(0, 2);
            step(1, 1);
            @(negedge clk);
        end
        done = 1;
        @(posedge clk);
        #2;
        cmp("scoreboard_drain", q0.size() + q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (>=1)
- SYNC_POL, 0, sync asserted level (0 = active-low)
REQ-002 Derived: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; CW=clog2(H_TOTAL); RW=clog2(V_TOTAL); AW=clog2(H_ACTIVE*V_ACTIVE).
REQ-003 Ports SHALL be (name direction width meaning):
- clk in 1 system clock; sole clock
- rst in 1 synchronous, active-high reset
- enable in 1 run when high, freeze when low
- pixel_tick out 1 one-clk pulse per pixel period
- hsync out 1 horizontal sync, level per SYNC_POL
- vsync out 1 vertical sync, level per SYNC_POL
- active out 1 high inside visible region
- counter_out_col out CW horizontal position, 0..H_TOTAL-1
- counter_out_row out RW vertical position, 0..V_TOTAL-1
- counter_out_addr out AW linear visible-pixel address
- flag_col out 1 high during last pixel of each line
- flag_row out 1 high during last pixel of frame
- flag_addr out 1 high during last visible pixel of frame

Function
REQ-004 Divider counter SHALL count 0..CLK_DIV-1 while enable=1; pixel_tick=1 for exactly the clk in which divider==CLK_DIV-1 and enable=1; CLK_DIV=1 gives pixel_tick=enable.
REQ-005 On pixel_tick, col SHALL increment; col==H_TOTAL-1 wraps to 0 and row increments; row==V_TOTAL-1 with col wrap wraps row to 0.
REQ-006 enable=0 SHALL hold divider, col, row, addr and every output at current value; pixel_tick=0.
REQ-007 All outputs SHALL be registered and updated on the same clk edge as col/row (zero skew between position and decoded signals).
REQ-008 active=1 iff col<H_ACTIVE and row<V_ACTIVE.
REQ-009 hsync=SYNC_POL iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL; vsync same rule on row with V_* parameters.
REQ-010 addr SHALL increment by 1 on each pixel_tick leaving an active pixel, wrap to 0 when (row,col) wraps to (0,0), and hold during blanking; value equals row*H_ACTIVE+col in active region.
REQ-011 flag_col=1 iff col==H_TOTAL-1; flag_row=1 iff col==H_TOTAL-1 and row==V_TOTAL-1; flag_addr=1 iff addr==H_ACTIVE*V_ACTIVE-1 and active=1.
REQ-012 Flags are level outputs lasting one full pixel period (CLK_DIV clks), not single-clk pulses.
REQ-013 Arithmetic SHALL be unsigned; no counter SHALL exceed its TOTAL-1 or ACTIVE product-1.

Reset
REQ-014 rst=1 at a rising clk edge SHALL set divider, col, row, addr to 0; pixel_tick=0; active=1; hsync=vsync=~SYNC_POL; all flags 0; rst overrides enable.
REQ-015 rst asserted mid-frame SHALL restart timing at (0,0) on release, no partial-line completion.

Verification (H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1,CLK_DIV=2,SYNC_POL=0)
REQ-016 rst 2 clks, enable=1 -> pixel_tick every 2nd clk; col 0..7 then 0; row increments at col wrap.
REQ-017 Run one line -> hsync=0 exactly for col 5..6; active=1 col 0..3 on rows 0..2; flag_col high for col=7 only.
REQ-018 Run full frame (96 clks) -> addr 0..11 across active pixels, flag_addr at addr=11 (row2,col3); vsync=0 only row 4; flag_row at (5,7); next tick returns (0,0), addr=0.
REQ-019 Drop enable at (1,2) for 10 clks -> all outputs frozen, pixel_tick=0; resume continues at (1,3) with no skipped pixel.
REQ-020 Assert rst with enable=1 at (4,6) -> next edge col=row=addr=0, hsync=vsync=1, flags 0.
REQ-021 CLK_DIV=1 build -> pixel_tick tracks enable every clk; frame length 48 clks.
